// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between the EX/MEM and MEM/WB registers.
// Resolves beq/bne, runs loads/stores over a req/ack data-memory handshake
// (stalling the upstream pipe while an access is in flight), formats
// sub-word data and flags misaligned accesses and bus timeouts.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   opcode, RW, MtoR, MR, MW,
//   Branch, bne, zero          control from EX/MEM
//   aluANS, rd2, WN, b_tgt     address/result, store data, dest reg, branch target
//   dmem_req/we/addr/wdata/be  data-memory request (registered)
//   dmem_ack, dmem_rdata       one-cycle completion pulse and read data
//   stall, pcsrc, pc_tgt       hazard/branch controls to IF/ID (combinational)
//   RW_out, MtoR_out, rdata_out, aluANS_out, WN_out,
//   misalign_out, buserr_out   MEM/WB register contents
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        RW,
  input  logic        MtoR,
  input  logic        MR,
  input  logic        MW,
  input  logic        Branch,
  input  logic        bne,
  input  logic        zero,
  input  logic [31:0] aluANS,
  input  logic [31:0] rd2,
  input  logic [4:0]  WN,
  input  logic [31:0] b_tgt,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] pc_tgt,
  output logic        RW_out,
  output logic        MtoR_out,
  output logic [31:0] rdata_out,
  output logic [31:0] aluANS_out,
  output logic [4:0]  WN_out,
  output logic        misalign_out,
  output logic        buserr_out
);

  localparam int unsigned CNT_W = 8;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_buserr, w_buserr_nxt;
  logic [31:0]        r_hold, w_hold_nxt;

  logic               r_dmem_req, w_req_nxt;
  logic               r_dmem_we, w_we_nxt;
  logic [31:0]        r_dmem_addr, w_addr_nxt;
  logic [31:0]        r_dmem_wdata, w_wdata_nxt;
  logic [3:0]         r_dmem_be, w_be_nxt;

  logic               r_rw, w_rw_nxt;
  logic               r_mtor, w_mtor_nxt;
  logic [31:0]        r_rdata, w_rdata_nxt;
  logic [31:0]        r_alu, w_alu_nxt;
  logic [4:0]         r_wn, w_wn_nxt;
  logic               r_misalign, w_misalign_nxt;
  logic               r_buserr_out, w_buserr_out_nxt;

  logic               w_memop;
  logic               w_is_byte;
  logic               w_is_half;
  logic               w_misalign;
  logic               w_stall;
  logic [1:0]         w_k;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [31:0]        w_lane;
  logic [31:0]        w_ld_fmt;

  assign w_memop   = MR | MW;
  assign w_k       = aluANS[1:0];
  assign w_is_byte = (opcode == OP_LB) || (opcode == OP_LBU) || (opcode == OP_SB);
  assign w_is_half = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);

  // Bytes are always aligned; unknown opcodes fall through as word accesses.
  assign w_misalign = w_is_byte ? 1'b0 :
                      w_is_half ? aluANS[0] :
                                  (aluANS[1:0] != 2'b00);

  // Byte enables and lane-replicated store data.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = rd2;
    if (w_is_byte) begin
      w_be    = 4'(4'b0001 << w_k);
      w_wdata = {4{rd2[7:0]}};
    end else if (w_is_half) begin
      w_be    = 4'(4'b0011 << w_k);
      w_wdata = {2{rd2[15:0]}};
    end
  end

  // Selected little-endian lane moved down to bit 0, then extended.
  assign w_lane = dmem_rdata >> {w_k, 3'b000};

  always_comb begin
    case (opcode)
      OP_LB:   w_ld_fmt = {{24{w_lane[7]}}, w_lane[7:0]};
      OP_LBU:  w_ld_fmt = {24'd0, w_lane[7:0]};
      OP_LH:   w_ld_fmt = {{16{w_lane[15]}}, w_lane[15:0]};
      OP_LHU:  w_ld_fmt = {16'd0, w_lane[15:0]};
      default: w_ld_fmt = dmem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, stall and next values of all registered outputs.
  // MEM/WB defaults to a bubble; only IDLE (non-stalling) and DONE load it.
  always_comb begin
    w_state_nxt      = r_state;
    w_stall          = 1'b0;
    w_cnt_nxt        = r_cnt;
    w_buserr_nxt     = r_buserr;
    w_hold_nxt       = r_hold;
    w_req_nxt        = r_dmem_req;
    w_we_nxt         = r_dmem_we;
    w_addr_nxt       = r_dmem_addr;
    w_wdata_nxt      = r_dmem_wdata;
    w_be_nxt         = r_dmem_be;
    w_rw_nxt         = 1'b0;
    w_mtor_nxt       = 1'b0;
    w_rdata_nxt      = '0;
    w_alu_nxt        = '0;
    w_wn_nxt         = '0;
    w_misalign_nxt   = 1'b0;
    w_buserr_out_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_memop && !w_misalign) begin
          w_stall      = 1'b1;
          w_state_nxt  = S_ACCESS;
          w_req_nxt    = 1'b1;
          w_we_nxt     = MW;
          w_addr_nxt   = {aluANS[31:2], 2'b00};
          w_wdata_nxt  = w_wdata;
          w_be_nxt     = w_be;
          w_buserr_nxt = 1'b0;
        end else if (w_memop) begin
          w_misalign_nxt = 1'b1;
          w_alu_nxt      = aluANS;
          w_wn_nxt       = WN;
        end else begin
          w_rw_nxt   = RW;
          w_mtor_nxt = MtoR;
          w_alu_nxt  = aluANS;
          w_wn_nxt   = WN;
        end
      end

      S_ACCESS: begin
        w_stall   = 1'b1;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (dmem_ack) begin
          w_hold_nxt  = w_ld_fmt;
          w_req_nxt   = 1'b0;
          w_state_nxt = S_DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_buserr_nxt = 1'b1;
          w_req_nxt    = 1'b0;
          w_state_nxt  = S_DONE;
        end
      end

      S_DONE: begin
        w_state_nxt      = S_IDLE;
        w_rw_nxt         = RW & ~r_buserr;
        w_mtor_nxt       = MtoR & ~r_buserr;
        w_rdata_nxt      = r_buserr ? 32'd0 : r_hold;
        w_alu_nxt        = aluANS;
        w_wn_nxt         = WN;
        w_buserr_out_nxt = r_buserr;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_buserr     <= 1'b0;
      r_hold       <= '0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_be    <= '0;
      r_rw         <= 1'b0;
      r_mtor       <= 1'b0;
      r_rdata      <= '0;
      r_alu        <= '0;
      r_wn         <= '0;
      r_misalign   <= 1'b0;
      r_buserr_out <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_buserr     <= w_buserr_nxt;
      r_hold       <= w_hold_nxt;
      r_dmem_req   <= w_req_nxt;
      r_dmem_we    <= w_we_nxt;
      r_dmem_addr  <= w_addr_nxt;
      r_dmem_wdata <= w_wdata_nxt;
      r_dmem_be    <= w_be_nxt;
      r_rw         <= w_rw_nxt;
      r_mtor       <= w_mtor_nxt;
      r_rdata      <= w_rdata_nxt;
      r_alu        <= w_alu_nxt;
      r_wn         <= w_wn_nxt;
      r_misalign   <= w_misalign_nxt;
      r_buserr_out <= w_buserr_out_nxt;
    end
  end

  // Stall is held low while reset is asserted so the pipe is released at once.
  assign stall  = w_stall & ~reset;
  assign pcsrc  = ~stall & ((Branch & zero) | (bne & ~zero));
  assign pc_tgt = b_tgt;

  assign dmem_req     = r_dmem_req;
  assign dmem_we      = r_dmem_we;
  assign dmem_addr    = r_dmem_addr;
  assign dmem_wdata   = r_dmem_wdata;
  assign dmem_be      = r_dmem_be;
  assign RW_out       = r_rw;
  assign MtoR_out     = r_mtor;
  assign rdata_out    = r_rdata;
  assign aluANS_out   = r_alu;
  assign WN_out       = r_wn;
  assign misalign_out = r_misalign;
  assign buserr_out   = r_buserr_out;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int unsigned TO = 4;

  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2B;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        RW, MtoR, MR, MW, Branch, bne, zero;
  logic [31:0] aluANS, rd2, b_tgt;
  logic [4:0]  WN;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall, pcsrc;
  logic [31:0] pc_tgt;
  logic        RW_out, MtoR_out;
  logic [31:0] rdata_out, aluANS_out;
  logic [4:0]  WN_out;
  logic        misalign_out, buserr_out;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .RW(RW), .MtoR(MtoR),
    .MR(MR), .MW(MW), .Branch(Branch), .bne(bne), .zero(zero),
    .aluANS(aluANS), .rd2(rd2), .WN(WN), .b_tgt(b_tgt),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .pcsrc(pcsrc), .pc_tgt(pc_tgt),
    .RW_out(RW_out), .MtoR_out(MtoR_out), .rdata_out(rdata_out),
    .aluANS_out(aluANS_out), .WN_out(WN_out),
    .misalign_out(misalign_out), .buserr_out(buserr_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (access-size arithmetic) ----------------
  function automatic int size_of(input logic [5:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  function automatic bit is_misaligned(input logic [5:0] op, input logic [31:0] a);
    return (int'(a[1:0]) % size_of(op)) != 0;
  endfunction

  function automatic logic [3:0] be_of(input logic [5:0] op, input logic [31:0] a);
    int sz = size_of(op);
    if (sz == 4) return 4'hF;
    return 4'(((1 << sz) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] wdata_of(input logic [5:0] op, input logic [31:0] d);
    int sz = size_of(op);
    if (sz == 1) return 32'(32'(d[7:0]) * 32'h01010101);
    if (sz == 2) return 32'(32'(d[15:0]) * 32'h00010001);
    return d;
  endfunction

  function automatic logic [31:0] load_of(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] rd);
    int     sz = size_of(op);
    int     bits;
    longint lane;
    if (sz == 4) return rd;
    bits = 8 * sz;
    lane = longint'(rd >> (8 * int'(a[1:0]))) % (longint'(1) << bits);
    if ((op == LB || op == LH) && lane >= (longint'(1) << (bits - 1)))
      lane = lane - (longint'(1) << bits);
    return 32'(lane);
  endfunction

  task automatic drive_nop();
    opcode = 6'h00; RW = 0; MtoR = 0; MR = 0; MW = 0;
    Branch = 0; bne = 0; zero = 0;
    aluANS = '0; rd2 = '0; WN = '0; b_tgt = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    drive_nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall} !== '0) begin
      n_errors++;
      $display("FAIL reset_dmem: req=%b we=%b addr=%h wdata=%h be=%b stall=%b, want all 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall);
    end
    n_checks++;
    if ({RW_out, MtoR_out, rdata_out, aluANS_out, WN_out, misalign_out, buserr_out} !== '0) begin
      n_errors++;
      $display("FAIL reset_memwb: RW=%b MtoR=%b rdata=%h alu=%h WN=%0d mis=%b berr=%b, want all 0",
               RW_out, MtoR_out, rdata_out, aluANS_out, WN_out, misalign_out, buserr_out);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
  endtask

  // Aligned memop; ack_at in 1..TO gives the ACCESS cycle of the ack, otherwise none.
  task automatic run_memop(input string nm, input logic [5:0] op, input logic mr, input logic mw,
                           input logic rw, input logic mtor, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] wn, input int ack_at,
                           input logic [31:0] rdv, input logic br);
    int          n_acc;
    bit          berr;
    logic [31:0] exp_addr;
    berr     = !(ack_at >= 1 && ack_at <= int'(TO));
    n_acc    = berr ? int'(TO) : ack_at;
    exp_addr = {a[31:2], 2'b00};
    @(posedge clk); #1;
    opcode = op; MR = mr; MW = mw; RW = rw; MtoR = mtor; aluANS = a; rd2 = d; WN = wn;
    Branch = br; zero = 1'b1; bne = 1'b0; b_tgt = $urandom;
    @(negedge clk);
    n_checks++;
    if ({dmem_req, stall, pcsrc} !== 3'b010) begin
      n_errors++;
      $display("FAIL %s idle: req/stall/pcsrc=%b want 010", nm, {dmem_req, stall, pcsrc});
    end
    for (int i = 1; i <= n_acc; i++) begin
      @(posedge clk); #1 dmem_ack = 1'b0; dmem_rdata = $urandom;
      @(negedge clk);
      n_checks++;
      if ({dmem_req, stall, pcsrc, RW_out, WN_out} !== {3'b110, 1'b0, 5'd0}) begin
        n_errors++;
        $display("FAIL %s access%0d: req=%b stall=%b pcsrc=%b RW_out=%b WN_out=%0d want 1 1 0 0 0",
                 nm, i, dmem_req, stall, pcsrc, RW_out, WN_out);
      end
      n_checks++;
      if ({dmem_addr, dmem_we, dmem_be, dmem_wdata} !== {exp_addr, mw, be_of(op, a), wdata_of(op, d)})
      begin
        n_errors++;
        $display("FAIL %s bus%0d: addr=%h we=%b be=%b wdata=%h want %h %b %b %h", nm, i,
                 dmem_addr, dmem_we, dmem_be, dmem_wdata,
                 exp_addr, mw, be_of(op, a), wdata_of(op, d));
      end
      if (i == ack_at) begin dmem_ack = 1'b1; dmem_rdata = rdv; end
    end
    @(posedge clk); #1 dmem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dmem_req, stall, pcsrc} !== {2'b00, br}) begin
      n_errors++;
      $display("FAIL %s done: req/stall/pcsrc=%b want 00%b", nm, {dmem_req, stall, pcsrc}, br);
    end
    dmem_ack = 1'b1; dmem_rdata = $urandom;  // stray ack outside ACCESS
    @(posedge clk); #1 dmem_ack = 1'b0; drive_nop();
    @(negedge clk);
    n_checks++;
    if ({RW_out, MtoR_out, WN_out, aluANS_out, buserr_out, misalign_out, dmem_req} !==
        {rw & ~berr, mtor & ~berr, wn, a, berr, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL %s wb: RW=%b MtoR=%b WN=%0d alu=%h berr=%b mis=%b req=%b want %b %b %0d %h %b 0 0",
               nm, RW_out, MtoR_out, WN_out, aluANS_out, buserr_out, misalign_out, dmem_req,
               rw & ~berr, mtor & ~berr, wn, a, berr);
    end
    if (berr || !mw) begin
      n_checks++;
      if (rdata_out !== (berr ? 32'd0 : load_of(op, a, rdv))) begin
        n_errors++;
        $display("FAIL %s rdata: got %h want %h", nm, rdata_out,
                 berr ? 32'd0 : load_of(op, a, rdv));
      end
    end
  endtask

  task automatic run_misalign(input string nm, input logic [5:0] op, input logic mr,
                              input logic mw, input logic [31:0] a);
    @(posedge clk); #1;
    opcode = op; MR = mr; MW = mw; RW = 1'b1; MtoR = 1'b1; aluANS = a;
    rd2 = $urandom; WN = 5'($urandom_range(1, 31));
    @(negedge clk);
    n_checks++;
    if ({dmem_req, stall} !== 2'b00) begin
      n_errors++;
      $display("FAIL %s mis_idle: req/stall=%b want 00", nm, {dmem_req, stall});
    end
    @(posedge clk); #1 drive_nop();
    @(negedge clk);
    n_checks++;
    if ({misalign_out, RW_out, MtoR_out, buserr_out, dmem_req} !== 5'b10000) begin
      n_errors++;
      $display("FAIL %s mis_wb: mis/RW/MtoR/berr/req=%b want 10000", nm,
               {misalign_out, RW_out, MtoR_out, buserr_out, dmem_req});
    end
  endtask

  task automatic run_nonmem(input string nm, input logic rw, input logic mtor,
                            input logic [31:0] a, input logic [4:0] wn, input logic br,
                            input logic bn, input logic z, input logic [31:0] tgt);
    logic exp_pc;
    exp_pc = (br & z) | (bn & ~z);
    @(posedge clk); #1;
    opcode = 6'h00; MR = 0; MW = 0; RW = rw; MtoR = mtor; aluANS = a; WN = wn;
    Branch = br; bne = bn; zero = z; b_tgt = tgt; rd2 = $urandom;
    dmem_ack = 1'b1; dmem_rdata = $urandom;  // stray ack in IDLE
    @(negedge clk);
    n_checks++;
    if ({pcsrc, pc_tgt, stall, dmem_req} !== {exp_pc, tgt, 2'b00}) begin
      n_errors++;
      $display("FAIL %s branch: pcsrc=%b pc_tgt=%h stall=%b req=%b want %b %h 0 0",
               nm, pcsrc, pc_tgt, stall, dmem_req, exp_pc, tgt);
    end
    @(posedge clk); #1 dmem_ack = 1'b0; drive_nop();
    @(negedge clk);
    n_checks++;
    if ({RW_out, MtoR_out, aluANS_out, WN_out, rdata_out, misalign_out, buserr_out, dmem_req} !==
        {rw, mtor, a, wn, 32'd0, 3'b000}) begin
      n_errors++;
      $display("FAIL %s pass: RW=%b MtoR=%b alu=%h WN=%0d rdata=%h mis=%b berr=%b req=%b want %b %b %h %0d 0",
               nm, RW_out, MtoR_out, aluANS_out, WN_out, rdata_out, misalign_out, buserr_out,
               dmem_req, rw, mtor, a, wn);
    end
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    opcode = LW; MR = 1; MW = 0; RW = 1; MtoR = 1; aluANS = 32'h100; WN = 5'd3;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_pre: req=%b want 1", dmem_req);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({dmem_req, stall, RW_out, MtoR_out, rdata_out, aluANS_out, WN_out, misalign_out,
         buserr_out} !== '0) begin
      n_errors++;
      $display("FAIL rst_mid: req=%b stall=%b RW=%b WN=%0d rdata=%h alu=%h, want all 0",
               dmem_req, stall, RW_out, WN_out, rdata_out, aluANS_out);
    end
    @(posedge clk); #1 reset = 1'b0; drive_nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({dmem_req, stall, RW_out} !== 3'b000) begin
      n_errors++;
      $display("FAIL rst_mid_after: req/stall/RW=%b want 000", {dmem_req, stall, RW_out});
    end
  endtask

  task automatic test_directed();
    run_memop("lw_ack3", LW, 1, 0, 1, 1, 32'h100, 32'h0, 5'd9, 3, 32'hDEADBEEF, 1'b0);
    run_memop("lb", LB, 1, 0, 1, 1, 32'h103, 32'h0, 5'd4, 1, 32'h80123456, 1'b0);
    run_memop("lbu", LBU, 1, 0, 1, 1, 32'h103, 32'h0, 5'd5, 1, 32'h80123456, 1'b0);
    run_memop("lhu", LHU, 1, 0, 1, 1, 32'h102, 32'h0, 5'd6, 2, 32'h80123456, 1'b0);
    run_memop("sb", SB, 0, 1, 0, 0, 32'h201, 32'h000000AB, 5'd0, 1, 32'h0, 1'b1);
    run_memop("sw_timeout", SW, 0, 1, 0, 0, 32'h300, 32'h12345678, 5'd0, 0, 32'h0, 1'b0);
    run_memop("lh_timeout", LH, 1, 0, 1, 1, 32'h302, 32'h0, 5'd8, 0, 32'h0, 1'b0);
    run_memop("mr_mw_both", 6'h00, 1, 1, 0, 0, 32'h40C, 32'hCAFEF00D, 5'd0, TO, 32'h0, 1'b0);
    run_misalign("lw_mis", LW, 1, 0, 32'h102);
    run_misalign("sh_mis", SH, 0, 1, 32'h105);
    run_nonmem("beq_taken", 1, 0, 32'h55, 5'd2, 1, 0, 1, 32'h40);
    run_nonmem("bne_zero", 0, 0, 32'h0, 5'd0, 0, 1, 1, 32'h80);
    run_nonmem("bne_taken", 0, 0, 32'h1, 5'd0, 0, 1, 0, 32'hC0);
  endtask

  task automatic test_random();
    logic [5:0]  ops [10];
    logic [5:0]  op;
    logic [31:0] a;
    logic        mr, mw;
    int          sz;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'h00, 6'h3F};
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        run_nonmem("rnd_alu", 1'($urandom), 1'($urandom), $urandom, 5'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      end else begin
        op = ops[$urandom_range(0, 9)];
        sz = size_of(op);
        a  = $urandom;
        if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
        if (op == SB || op == SH || op == SW) begin mr = 0; mw = 1; end
        else if (op == 6'h00 || op == 6'h3F) begin mr = 1; mw = 1'($urandom); end
        else begin mr = 1; mw = 0; end
        if (is_misaligned(op, a))
          run_misalign("rnd_mis", op, mr, mw, a);
        else
          run_memop("rnd_mem", op, mr, mw, ~mw, ~mw, a, $urandom, 5'($urandom),
                    $urandom_range(1, TO + 1), $urandom, 1'($urandom));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
